// File: rtl/game_clock_ctrl.sv
// game_clock_ctrl
// Basketball game clock. Counts a period down at TICK_HZ resolution
// (mm:ss.t), sequences regulation and overtime periods, supports
// pause/resume and manual time load while stopped, and drives an
// end-of-period horn window plus a game-over flag.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_STOP  | clock paused; manual load allowed; start_stop edge runs it
// ST_RUN   | counting down on each tick; start_stop edge pauses it
// ST_EXPIRED | time at 0:00.0, horn sounding; next_per edge advances
// ST_FINAL | game over; outputs frozen (horn finishes), reset only exit
//
// Ports
//   i_clk         board oscillator
//   i_reset       asynchronous, active-low reset
//   i_start_stop  button level, rising edge toggles run/stop
//   i_next_per    button level, rising edge advances an expired period
//   i_tie         scores-tied level, sampled with the next_per edge
//   i_load_en     loads i_load_min / i_load_sec while stopped
//   i_load_min    minutes to load
//   i_load_sec    seconds to load (clamped to 59)
//   o_min/o_sec/o_tenths  time remaining
//   o_period      current period, 1-based, overtime continues numbering
//   o_running     high in RUN
//   o_under_min   high when minutes are zero (display switches to ss.t)
//   o_period_end  high in EXPIRED
//   o_buzzer      horn drive
//   o_game_over   high in FINAL
module game_clock_ctrl #(
    parameter int CLK_HZ      = 50000000,
    parameter int TICK_HZ     = 10,
    parameter int PERIOD_MIN  = 10,
    parameter int OT_MIN      = 5,
    parameter int NUM_PERIODS = 4,
    parameter int BUZZ_TICKS  = 20,
    parameter int PER_W       = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start_stop,
    input  logic             i_next_per,
    input  logic             i_tie,
    input  logic             i_load_en,
    input  logic [6:0]       i_load_min,
    input  logic [5:0]       i_load_sec,
    output logic [6:0]       o_min,
    output logic [5:0]       o_sec,
    output logic [3:0]       o_tenths,
    output logic [PER_W-1:0] o_period,
    output logic             o_running,
    output logic             o_under_min,
    output logic             o_period_end,
    output logic             o_buzzer,
    output logic             o_game_over
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PSC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BZ_W  = (BUZZ_TICKS > 0) ? $clog2(BUZZ_TICKS + 1) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(DIV - 1);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_EXPIRED,
        ST_FINAL
    } state_t;

    state_t            r_state;
    logic [6:0]        r_min;
    logic [5:0]        r_sec;
    logic [3:0]        r_tenths;
    logic [PER_W-1:0]  r_period;
    logic              r_running;
    logic              r_period_end;
    logic              r_game_over;
    logic [BZ_W-1:0]   r_buzz_cnt;
    logic [PSC_W-1:0]  r_psc;

    logic [1:0]        r_ss_sync;
    logic [1:0]        r_np_sync;
    logic [1:0]        r_tie_sync;
    logic              r_ss_d;
    logic              r_np_d;

    logic              w_ss_edge;
    logic              w_np_edge;
    logic              w_psc_en;
    logic              w_tick;
    logic              w_adv_reg;
    logic              w_adv_ot;
    logic              w_per_load;
    logic              w_time_zero;
    logic              w_last_tenth;
    logic [6:0]        w_dec_min;
    logic [5:0]        w_dec_sec;
    logic [3:0]        w_dec_tenths;
    logic [5:0]        w_load_sec_clamped;

    // Button and tie synchronisers plus edge-detect history
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_ss_sync  <= 2'b00;
            r_np_sync  <= 2'b00;
            r_tie_sync <= 2'b00;
            r_ss_d     <= 1'b0;
            r_np_d     <= 1'b0;
        end else begin
            r_ss_sync  <= {r_ss_sync[0], i_start_stop};
            r_np_sync  <= {r_np_sync[0], i_next_per};
            r_tie_sync <= {r_tie_sync[0], i_tie};
            r_ss_d     <= r_ss_sync[1];
            r_np_d     <= r_np_sync[1];
        end
    end

    assign w_ss_edge = r_ss_sync[1] & ~r_ss_d;
    assign w_np_edge = r_np_sync[1] & ~r_np_d;

    assign w_adv_reg  = int'(r_period) < NUM_PERIODS;
    assign w_adv_ot   = !w_adv_reg && r_tie_sync[1] && (r_period != '1);
    assign w_per_load = (r_state == ST_EXPIRED) && w_np_edge && (w_adv_reg || w_adv_ot);

    // The prescaler also runs while the horn counts down, so the horn
    // length is measured in ticks even after the clock has stopped.
    assign w_psc_en = (r_state == ST_RUN) || (r_buzz_cnt != '0);
    assign w_tick   = w_psc_en && (r_psc == PSC_LAST);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_psc <= '0;
        end else if (w_per_load) begin
            r_psc <= '0;
        end else if (w_psc_en) begin
            r_psc <= (r_psc == PSC_LAST) ? '0 : r_psc + 1'b1;
        end
    end

    // mm:ss.t decrement with borrow
    always_comb begin
        w_dec_min    = r_min;
        w_dec_sec    = r_sec;
        w_dec_tenths = r_tenths;
        if (r_tenths != 4'd0) begin
            w_dec_tenths = r_tenths - 4'd1;
        end else begin
            w_dec_tenths = 4'd9;
            if (r_sec != 6'd0) begin
                w_dec_sec = r_sec - 6'd1;
            end else begin
                w_dec_sec = 6'd59;
                w_dec_min = r_min - 7'd1;
            end
        end
    end

    assign w_time_zero  = (r_min == 7'd0) && (r_sec == 6'd0) && (r_tenths == 4'd0);
    assign w_last_tenth = (r_min == 7'd0) && (r_sec == 6'd0) && (r_tenths == 4'd1);
    assign w_load_sec_clamped = (i_load_sec > 6'd59) ? 6'd59 : i_load_sec;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= ST_STOP;
            r_min        <= 7'(PERIOD_MIN);
            r_sec        <= 6'd0;
            r_tenths     <= 4'd0;
            r_period     <= PER_W'(1);
            r_running    <= 1'b0;
            r_period_end <= 1'b0;
            r_game_over  <= 1'b0;
            r_buzz_cnt   <= '0;
        end else begin
            if (w_tick && (r_buzz_cnt != '0)) begin
                r_buzz_cnt <= r_buzz_cnt - 1'b1;
            end
            case (r_state)
                ST_STOP: begin
                    if (i_load_en) begin
                        r_min    <= i_load_min;
                        r_sec    <= w_load_sec_clamped;
                        r_tenths <= 4'd0;
                    end else if (w_ss_edge) begin
                        if (w_time_zero) begin
                            r_state      <= ST_EXPIRED;
                            r_period_end <= 1'b1;
                            r_buzz_cnt   <= BZ_W'(BUZZ_TICKS);
                        end else begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_tick && !w_time_zero) begin
                        r_min    <= w_dec_min;
                        r_sec    <= w_dec_sec;
                        r_tenths <= w_dec_tenths;
                    end
                    // Expiry outranks a simultaneous pause request
                    if (w_tick && w_last_tenth) begin
                        r_state      <= ST_EXPIRED;
                        r_running    <= 1'b0;
                        r_period_end <= 1'b1;
                        r_buzz_cnt   <= BZ_W'(BUZZ_TICKS);
                    end else if (w_ss_edge) begin
                        r_state   <= ST_STOP;
                        r_running <= 1'b0;
                    end
                end
                ST_EXPIRED: begin
                    if (w_np_edge) begin
                        r_period_end <= 1'b0;
                        if (w_adv_reg || w_adv_ot) begin
                            r_state    <= ST_STOP;
                            r_period   <= r_period + 1'b1;
                            r_min      <= w_adv_reg ? 7'(PERIOD_MIN) : 7'(OT_MIN);
                            r_sec      <= 6'd0;
                            r_tenths   <= 4'd0;
                            r_buzz_cnt <= '0;
                        end else begin
                            r_state     <= ST_FINAL;
                            r_game_over <= 1'b1;
                        end
                    end
                end
                ST_FINAL: begin
                end
                default: begin
                    r_state <= ST_STOP;
                end
            endcase
        end
    end

    assign o_min        = r_min;
    assign o_sec        = r_sec;
    assign o_tenths     = r_tenths;
    assign o_period     = r_period;
    assign o_running    = r_running;
    assign o_under_min  = (r_min == 7'd0);
    assign o_period_end = r_period_end;
    assign o_buzzer     = (r_buzz_cnt != '0);
    assign o_game_over  = r_game_over;

endmodule
